// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I/M opcode, ALU-op and decoded-instruction types
package rv32_pkg;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_OP_IMM   = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    // ALU_ADD is zero so an all-zero decoded entry is a harmless add
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        mul_div;
        logic        illegal;
        logic        ecall;
        logic        ebreak;
    } decoded_instr_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// rtl/decode_skid_buffer.sv - generic 2-slot valid/ready buffer with registered in_ready_o
module decode_skid_buffer
    import rv32_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    occ_e r_state;
    occ_e w_state_nxt;
    logic r_in_ready;
    T     r_slot0;
    T     r_slot1;
    logic w_in_fire;
    logic w_out_fire;
    logic w_ld0_in;
    logic w_ld0_skid;
    logic w_ld1;

    assign w_in_fire  = in_valid_i && r_in_ready;
    assign w_out_fire = (r_state != OCC_EMPTY) && out_ready_i;

    // Occupancy next-state and slot load selects; flush overrides any handshake
    always_comb begin
        w_state_nxt = r_state;
        w_ld0_in    = 1'b0;
        w_ld0_skid  = 1'b0;
        w_ld1       = 1'b0;
        if (flush_i) begin
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = OCC_ONE;
                        w_ld0_in    = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld0_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = OCC_TWO;
                        w_ld1       = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt = OCC_ONE;
                        w_ld0_skid  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = OCC_EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is the registered "skid will be empty" flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != OCC_TWO);
        end
    end

    // Payload slots; slot 1 promotes into slot 0 when the output drains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            if (w_ld0_in) begin
                r_slot0 <= in_data_i;
            end else if (w_ld0_skid) begin
                r_slot0 <= r_slot1;
            end
            if (w_ld1) begin
                r_slot1 <= in_data_i;
            end
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state != OCC_EMPTY);
    assign out_data_o  = r_slot0;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I/M decode stage with skid buffer and flush
module decode_stage
    import rv32_pkg::*;
#(
    parameter int HAS_M         = 1,
    parameter int CHECK_ILLEGAL = 1,
    parameter int PC_W          = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_instr_i,
    input  logic [PC_W-1:0]      in_pc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output decoded_instr_t       out_decoded_o,
    output logic [PC_W-1:0]      out_pc_o
);

    typedef struct packed {
        decoded_instr_t       dec;
        logic [PC_W-1:0]      pc;
    } payload_t;

    decoded_instr_t w_dec;
    logic           w_bad;
    logic [2:0]     w_f3;
    logic [6:0]     w_f7;
    payload_t       w_payload_in;
    payload_t       w_payload_out;

    assign w_f3 = in_instr_i[14:12];
    assign w_f7 = in_instr_i[31:25];

    // Combinational decode ahead of storage; illegal encodings collapse to zero fields
    always_comb begin
        w_dec = '0;
        w_bad = 1'b0;
        case (in_instr_i[6:0])
            OP_LUI: begin
                w_dec.rd          = in_instr_i[11:7];
                w_dec.imm         = imm_u(in_instr_i);
                w_dec.alu_op      = ALU_PASS;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.rd          = in_instr_i[11:7];
                w_dec.imm         = imm_u(in_instr_i);
                w_dec.alu_op      = ALU_ADD;
                w_dec.alu_src_imm = 1'b1;
                w_dec.alu_src_pc  = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_JAL: begin
                w_dec.rd        = in_instr_i[11:7];
                w_dec.imm       = imm_j(in_instr_i);
                w_dec.jump      = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                w_bad             = (w_f3 != 3'b000);
                w_dec.rd          = in_instr_i[11:7];
                w_dec.rs1         = in_instr_i[19:15];
                w_dec.imm         = imm_i(in_instr_i);
                w_dec.jump        = 1'b1;
                w_dec.jalr        = 1'b1;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_BRANCH: begin
                w_bad        = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                w_dec.rs1    = in_instr_i[19:15];
                w_dec.rs2    = in_instr_i[24:20];
                w_dec.imm    = imm_b(in_instr_i);
                w_dec.funct3 = w_f3;
                w_dec.alu_op = ALU_SUB;
                w_dec.branch = 1'b1;
            end
            OP_LOAD: begin
                w_bad             = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                w_dec.rd          = in_instr_i[11:7];
                w_dec.rs1         = in_instr_i[19:15];
                w_dec.imm         = imm_i(in_instr_i);
                w_dec.funct3      = w_f3;
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_read    = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OP_STORE: begin
                w_bad             = (w_f3 > 3'b010);
                w_dec.rs1         = in_instr_i[19:15];
                w_dec.rs2         = in_instr_i[24:20];
                w_dec.imm         = imm_s(in_instr_i);
                w_dec.funct3      = w_f3;
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_write   = 1'b1;
            end
            OP_OP_IMM: begin
                w_dec.rd          = in_instr_i[11:7];
                w_dec.rs1         = in_instr_i[19:15];
                w_dec.imm         = imm_i(in_instr_i);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                case (w_f3)
                    3'b000: w_dec.alu_op = ALU_ADD;
                    3'b010: w_dec.alu_op = ALU_SLT;
                    3'b011: w_dec.alu_op = ALU_SLTU;
                    3'b100: w_dec.alu_op = ALU_XOR;
                    3'b110: w_dec.alu_op = ALU_OR;
                    3'b111: w_dec.alu_op = ALU_AND;
                    3'b001: begin
                        w_bad        = (w_f7 != F7_BASE);
                        w_dec.alu_op = ALU_SLL;
                        w_dec.imm    = {27'd0, in_instr_i[24:20]};
                    end
                    default: begin
                        w_bad        = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
                        w_dec.alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        w_dec.imm    = {27'd0, in_instr_i[24:20]};
                    end
                endcase
            end
            OP_OP: begin
                w_dec.rd        = in_instr_i[11:7];
                w_dec.rs1       = in_instr_i[19:15];
                w_dec.rs2       = in_instr_i[24:20];
                w_dec.reg_write = 1'b1;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        3'b000:  w_dec.alu_op = ALU_ADD;
                        3'b001:  w_dec.alu_op = ALU_SLL;
                        3'b010:  w_dec.alu_op = ALU_SLT;
                        3'b011:  w_dec.alu_op = ALU_SLTU;
                        3'b100:  w_dec.alu_op = ALU_XOR;
                        3'b101:  w_dec.alu_op = ALU_SRL;
                        3'b110:  w_dec.alu_op = ALU_OR;
                        default: w_dec.alu_op = ALU_AND;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                    w_dec.alu_op = ALU_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                    w_dec.alu_op = ALU_SRA;
                end else if (w_f7 == F7_MULDIV && HAS_M != 0) begin
                    w_dec.mul_div = 1'b1;
                    case (w_f3)
                        3'b000:  w_dec.alu_op = ALU_MUL;
                        3'b001:  w_dec.alu_op = ALU_MULH;
                        3'b010:  w_dec.alu_op = ALU_MULHSU;
                        3'b011:  w_dec.alu_op = ALU_MULHU;
                        3'b100:  w_dec.alu_op = ALU_DIV;
                        3'b101:  w_dec.alu_op = ALU_DIVU;
                        3'b110:  w_dec.alu_op = ALU_REM;
                        default: w_dec.alu_op = ALU_REMU;
                    endcase
                end else begin
                    w_bad = 1'b1;
                end
            end
            OP_MISC_MEM: begin
                w_bad = 1'b0;
            end
            OP_SYSTEM: begin
                if (in_instr_i == INSTR_ECALL) begin
                    w_dec.ecall = 1'b1;
                end else if (in_instr_i == INSTR_EBREAK) begin
                    w_dec.ebreak = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
        if (in_instr_i[1:0] != 2'b11) begin
            w_bad = 1'b1;
        end
        if (w_bad) begin
            w_dec         = '0;
            w_dec.illegal = (CHECK_ILLEGAL != 0);
        end
    end

    assign w_payload_in.dec = w_dec;
    assign w_payload_in.pc  = in_pc_i;

    decode_skid_buffer #(
        .T (payload_t)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (w_payload_in),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (w_payload_out)
    );

    assign out_decoded_o = w_payload_out.dec;
    assign out_pc_o      = w_payload_out.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (HAS_M=1 and HAS_M=0 builds)
module tb_decode_stage;
    import rv32_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           out_ready;
    logic [31:0]    in_instr;
    logic [31:0]    in_pc;
    logic           in_ready, in_ready_n;
    logic           out_valid, out_valid_n;
    decoded_instr_t dec, dec_n;
    logic [31:0]    out_pc, out_pc_n;

    always #5 clk = ~clk;

    decode_stage #(.HAS_M(1), .CHECK_ILLEGAL(1), .PC_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_decoded_o(dec), .out_pc_o(out_pc)
    );

    decode_stage #(.HAS_M(0), .CHECK_ILLEGAL(1), .PC_W(32)) u_dut_nom (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_n),
        .in_instr_i(in_instr), .in_pc_i(in_pc),
        .out_valid_o(out_valid_n), .out_ready_i(out_ready),
        .out_decoded_o(dec_n), .out_pc_o(out_pc_n)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu;
        logic        rw, br, il, ec, eb, md, nom_il;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
    } sb_t;

    localparam int NV = 15;
    vec_t tbl [NV];
    sb_t  sb [$];
    vec_t drive_vec;
    int   cyc = 0;
    bit   chk_lat;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;

    // Free-running cycle counter for latency/throughput measurement
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] imm, input alu_op_e alu, input logic rw, input logic br,
                                input logic il, input logic ec, input logic eb, input logic md,
                                input logic nom_il);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rd = rd; v.imm = imm; v.alu = alu;
        v.rw = rw; v.br = br; v.il = il; v.ec = ec; v.eb = eb; v.md = md; v.nom_il = nom_il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input sb_t e);
        decoded_instr_t ill;
        string t;
        t = $sformatf("%08h", e.v.instr);
        chk({t, " pc"}, out_pc, e.v.pc);
        chk({t, " rd"}, dec.rd, e.v.rd);
        chk({t, " imm"}, dec.imm, e.v.imm);
        chk({t, " alu_op"}, dec.alu_op, e.v.alu);
        chk({t, " reg_write"}, dec.reg_write, e.v.rw);
        chk({t, " branch"}, dec.branch, e.v.br);
        chk({t, " illegal"}, dec.illegal, e.v.il);
        chk({t, " ecall"}, dec.ecall, e.v.ec);
        chk({t, " ebreak"}, dec.ebreak, e.v.eb);
        chk({t, " mul_div"}, dec.mul_div, e.v.md);
        if (e.v.il) begin
            ill = '0;
            ill.illegal = 1'b1;
            chk({t, " illegal_fields"}, dec, ill);
        end
        chk({t, " nom_valid"}, out_valid_n, 1'b1);
        chk({t, " nom_pc"}, out_pc_n, e.v.pc);
        chk({t, " nom_illegal"}, dec_n.illegal, e.v.nom_il);
        if (e.v.nom_il) chk({t, " nom_reg_write"}, dec_n.reg_write, 1'b0);
        if (chk_lat) chk({t, " latency"}, cyc - e.cyc, 1);
    endtask

    // Scoreboard monitor: pop on output transfer, push on input transfer, clear on flush/reset
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_output: got entry pc=%08h, required none", out_pc);
                    end else begin
                        e = sb.pop_front();
                        check_entry(e);
                        n_out++;
                    end
                end
                if (in_valid && in_ready) begin
                    e.v   = drive_vec;
                    e.cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic present(input vec_t v);
        in_valid  = 1'b1;
        in_instr  = v.instr;
        in_pc     = v.pc;
        drive_vec = v;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v);
        present(v);
        wait_accept();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", sb.size(), 0);
        @(negedge clk);
        chk("drain idle out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string name, input bit data_zero);
        @(negedge clk);
        chk({name, " out_valid"}, out_valid, 1'b0);
        chk({name, " in_ready"}, in_ready, 1'b1);
        chk({name, " nom out_valid"}, out_valid_n, 1'b0);
        if (data_zero) begin
            chk({name, " out_decoded"}, dec, '0);
            chk({name, " out_pc"}, out_pc, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk({name, " nothing emerges"}, out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        tbl[0]  = mk(32'h00500093, 32'h100, 5'd1, 32'd5,        ALU_ADD,  1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(32'h402081B3, 32'h104, 5'd3, 32'd0,        ALU_SUB,  1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(32'hFE208EE3, 32'h108, 5'd0, 32'hFFFFFFFC, ALU_SUB,  0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(32'h022081B3, 32'h10C, 5'd3, 32'd0,        ALU_MUL,  1, 0, 0, 0, 0, 1, 1);
        tbl[4]  = mk(32'h00003083, 32'h110, 5'd0, 32'd0,        ALU_ADD,  0, 0, 1, 0, 0, 0, 1);
        tbl[5]  = mk(32'h00000073, 32'h114, 5'd0, 32'd0,        ALU_ADD,  0, 0, 0, 1, 0, 0, 0);
        tbl[6]  = mk(32'h00100073, 32'h118, 5'd0, 32'd0,        ALU_ADD,  0, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(32'h10500073, 32'h11C, 5'd0, 32'd0,        ALU_ADD,  0, 0, 1, 0, 0, 0, 1);
        tbl[8]  = mk(32'h0FF0000F, 32'h120, 5'd0, 32'd0,        ALU_ADD,  0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(32'h123450B7, 32'h124, 5'd1, 32'h12345000, ALU_PASS, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(32'h40315093, 32'h128, 5'd1, 32'd3,        ALU_SRA,  1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(32'h40209093, 32'h12C, 5'd0, 32'd0,        ALU_ADD,  0, 0, 1, 0, 0, 0, 1);
        tbl[12] = mk(32'h00000001, 32'h130, 5'd0, 32'd0,        ALU_ADD,  0, 0, 1, 0, 0, 0, 1);
        tbl[13] = mk(32'h00001067, 32'h134, 5'd0, 32'd0,        ALU_ADD,  0, 0, 1, 0, 0, 0, 1);
        tbl[14] = mk(32'h0040A103, 32'h138, 5'd2, 32'd4,        ALU_ADD,  1, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; drive_vec = '0; chk_lat = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_decoded", dec, '0);
        chk("reset out_pc", out_pc, 0);
        chk("reset nom in_ready", in_ready_n, 1'b1);
        @(posedge clk);
        #1;

        // Streamed table with ready held: one per cycle, one-cycle latency
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        t0 = cyc;
        for (int i = 0; i < NV; i++) send(tbl[i]);
        chk("stream throughput cycles", cyc - t0, NV);
        wait_drain();
        chk("stream outputs", n_out, NV);
        chk_lat = 1'b0;

        // Backpressure: two accepted, third held until ready returns
        out_ready = 1'b0;
        t0 = n_out;
        send(tbl[9]);
        send(tbl[10]);
        present(tbl[0]);
        @(negedge clk);
        chk("bp in_ready after two", in_ready, 1'b0);
        chk("bp out_valid", out_valid, 1'b1);
        chk("bp head pc", out_pc, tbl[9].pc);
        repeat (2) begin
            @(negedge clk);
            chk("bp third held", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept();
        wait_drain();
        chk("bp outputs", n_out - t0, 3);

        // Flush in TWO together with an offered instruction
        out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[2]);
        present(tbl[5]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_cleared("flush two", 1'b0);

        // Flush in ONE while the input would otherwise be accepted
        out_ready = 1'b0;
        send(tbl[6]);
        present(tbl[14]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_cleared("flush one", 1'b0);

        // Reset in TWO together with an offered instruction also clears data
        out_ready = 1'b0;
        send(tbl[3]);
        send(tbl[9]);
        present(tbl[0]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check_cleared("reset two", 1'b1);

        // Recovery after reset
        t0 = n_out;
        chk_lat = 1'b1;
        send(tbl[14]);
        wait_drain();
        chk("recovery outputs", n_out - t0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
